// File: rtl/attack_pkg.sv
// Shared types for the attack sequencer: FSM states and victim-mode encodings.
package attack_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_PRE,
    ST_VICTIM,
    ST_WAIT_RSA,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_BASELINE = 2'd0,
    MODE_SWITCH   = 2'd1,
    MODE_RSA      = 2'd2
  } mode_e;

  // Reserved encoding 3 runs as a baseline capture.
  function automatic mode_e decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return MODE_SWITCH;
      2'd2:    return MODE_RSA;
      default: return MODE_BASELINE;
    endcase
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter that saturates at zero and flags the zero count.
module cycle_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero_c
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/attack_sequencer.sv
// Sequences one side-channel capture: RO start, quiet period, victim activity,
// then waits for the capture to drain, with a bounded wait on each handshake.
module attack_sequencer
  import attack_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic [1:0]           mode,
  input  logic [CNT_WIDTH-1:0] pre_cycles,
  input  logic [CNT_WIDTH-1:0] victim_cycles,
  input  logic                 ro_done,
  input  logic                 rsa_done,
  output logic                 ro_go,
  output logic                 switcher_en,
  output logic                 rsa_go,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [CNT_WIDTH-1:0] pre_q, pre_d, victim_q, victim_d;
  logic                 ro_seen_q, ro_seen_d;
  logic                 ro_go_q, ro_go_d, switcher_en_q, switcher_en_d;
  logic                 rsa_go_q, rsa_go_d, busy_q, busy_d;
  logic                 done_q, done_d, timeout_q, timeout_d;

  logic                 ph_load, ph_dec, ph_zero;
  logic [CNT_WIDTH-1:0] ph_val;
  logic                 to_load, to_dec, to_zero;
  logic                 pre_end, abort;

  cycle_timer #(.W(CNT_WIDTH)) u_phase_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .dec      (ph_dec),
    .zero_c   (ph_zero)
  );

  cycle_timer #(.W(CNT_WIDTH)) u_timeout_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .load_val (CNT_WIDTH'(TIMEOUT_CYCLES - 1)),
    .dec      (to_dec),
    .zero_c   (to_zero)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    pre_d     = pre_q;
    victim_d  = victim_q;
    ro_seen_d = ro_seen_q;
    timeout_d = timeout_q;
    ph_load   = 1'b0;
    ph_val    = pre_q - CNT_WIDTH'(1);
    ph_dec    = 1'b0;
    to_dec    = 1'b0;
    pre_end   = 1'b0;
    abort     = 1'b0;

    // Capture may finish before DRAIN; remember it so DRAIN can exit at once.
    if (ro_done && ((state_q == ST_PRE) || (state_q == ST_VICTIM) || (state_q == ST_WAIT_RSA))) begin
      ro_seen_d = 1'b1;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          mode_d    = decode_mode(mode);
          pre_d     = pre_cycles;
          victim_d  = victim_cycles;
          ro_seen_d = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (pre_q == '0) begin
          pre_end = 1'b1;
        end else begin
          ph_load = 1'b1;
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (ph_zero) pre_end = 1'b1;
        else         ph_dec  = 1'b1;
      end
      ST_VICTIM: begin
        if (mode_q == MODE_RSA) state_d = ST_WAIT_RSA;
        else if (ph_zero)       state_d = ST_DRAIN;
        else                    ph_dec  = 1'b1;
      end
      ST_WAIT_RSA: begin
        // rsa_go_q marks the first WAIT_RSA cycle; a done seen then is stale.
        if (rsa_done && !rsa_go_q) state_d = ST_DRAIN;
        else if (to_zero)          abort   = 1'b1;
        else                       to_dec  = 1'b1;
      end
      ST_DRAIN: begin
        if (ro_done || ro_seen_q) begin
          state_d   = ST_DONE;
          ro_seen_d = 1'b0;
        end else if (to_zero) begin
          abort = 1'b1;
        end else begin
          to_dec = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pre_end) begin
      if (mode_q == MODE_RSA) begin
        state_d = ST_VICTIM;
      end else if ((mode_q == MODE_SWITCH) && (victim_q != '0)) begin
        state_d = ST_VICTIM;
        ph_load = 1'b1;
        ph_val  = victim_q - CNT_WIDTH'(1);
      end else begin
        state_d = ST_DRAIN;
      end
    end

    if (abort) begin
      state_d   = ST_DONE;
      timeout_d = 1'b1;
    end

    to_load       = (state_d != state_q) && ((state_d == ST_WAIT_RSA) || (state_d == ST_DRAIN));
    ro_go_d       = (state_q == ST_ARM);
    switcher_en_d = (state_q == ST_VICTIM) && (mode_q == MODE_SWITCH) && !abort;
    rsa_go_d      = (state_q == ST_VICTIM) && (mode_q == MODE_RSA);
    busy_d        = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mode_q        <= MODE_BASELINE;
      pre_q         <= '0;
      victim_q      <= '0;
      ro_seen_q     <= 1'b0;
      ro_go_q       <= 1'b0;
      switcher_en_q <= 1'b0;
      rsa_go_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      pre_q         <= pre_d;
      victim_q      <= victim_d;
      ro_seen_q     <= ro_seen_d;
      ro_go_q       <= ro_go_d;
      switcher_en_q <= switcher_en_d;
      rsa_go_q      <= rsa_go_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign ro_go       = ro_go_q;
  assign switcher_en = switcher_en_q;
  assign rsa_go      = rsa_go_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_attack_sequencer.sv
// Directed bench for attack_sequencer: a wide-timeout instance (a) and an
// 8-bit, 64-cycle-timeout instance (b) share stimulus; cycle 0 is the go cycle.
module tb_attack_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] pre_cycles = '0;
  logic [15:0] victim_cycles = '0;
  logic        ro_done = 1'b0;
  logic        rsa_done = 1'b0;

  logic a_ro_go, a_sw, a_rsa_go, a_busy, a_done, a_tmo;
  logic b_ro_go, b_sw, b_rsa_go, b_busy, b_done, b_tmo;

  attack_sequencer #(.CNT_WIDTH(16), .TIMEOUT_CYCLES(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .pre_cycles(pre_cycles), .victim_cycles(victim_cycles),
    .ro_done(ro_done), .rsa_done(rsa_done),
    .ro_go(a_ro_go), .switcher_en(a_sw), .rsa_go(a_rsa_go),
    .busy(a_busy), .done(a_done), .timeout(a_tmo)
  );

  attack_sequencer #(.CNT_WIDTH(8), .TIMEOUT_CYCLES(64)) dut_b (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .pre_cycles(pre_cycles[7:0]), .victim_cycles(victim_cycles[7:0]),
    .ro_done(ro_done), .rsa_done(rsa_done),
    .ro_go(b_ro_go), .switcher_en(b_sw), .rsa_go(b_rsa_go),
    .busy(b_busy), .done(b_done), .timeout(b_tmo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bits: 5 ro_go, 4 switcher_en, 3 rsa_go, 2 busy, 1 done, 0 timeout
  logic [5:0] obs [2];
  assign obs[0] = {a_ro_go, a_sw, a_rsa_go, a_busy, a_done, a_tmo};
  assign obs[1] = {b_ro_go, b_sw, b_rsa_go, b_busy, b_done, b_tmo};

  int n_tests = 0;
  int n_fail  = 0;
  int t0;
  int n_ro [2], ro_at [2], n_sw [2], sw_first [2], n_rsa [2], rsa_at [2];
  int done_at [2], tmo_done [2];

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; go = 1'b0; ro_done = 1'b0; rsa_done = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // ro_at/ro_off/rsa_pulse/rsa_at: cycle at whose end the input changes (-1 never, ro_at 0 = high from go)
  task automatic run(input logic [1:0] m, input int pre, input int vic, input int ro_on,
                     input int ro_off, input int rsa_pulse, input int rsa_on,
                     input bit go_busy, input int ncyc);
    for (int i = 0; i < 2; i++) begin
      n_ro[i] = 0; ro_at[i] = -1; n_sw[i] = 0; sw_first[i] = -1;
      n_rsa[i] = 0; rsa_at[i] = -1; done_at[i] = -1; tmo_done[i] = -1;
    end
    @(posedge clk); #1;
    t0 = cyc; mode = m; pre_cycles = 16'(pre); victim_cycles = 16'(vic); go = 1'b1;
    if (ro_on == 0) ro_done = 1'b1;
    @(posedge clk); #1;
    go = 1'b0; mode = 2'd0; pre_cycles = '0; victim_cycles = 16'd7;
    for (int k = 1; k <= ncyc; k++) begin
      do @(negedge clk); while (cyc - t0 < k);
      for (int i = 0; i < 2; i++) begin
        if (obs[i][5]) begin n_ro[i]++; ro_at[i] = k; end
        if (obs[i][4]) begin if (n_sw[i] == 0) sw_first[i] = k; n_sw[i]++; end
        if (obs[i][3]) begin n_rsa[i]++; rsa_at[i] = k; end
        if (obs[i][1] && done_at[i] < 0) begin done_at[i] = k; tmo_done[i] = int'(obs[i][0]); end
      end
      if (k == ro_on) ro_done = 1'b1;
      if (k == ro_off) ro_done = 1'b0;
      if (k == rsa_pulse) rsa_done = 1'b1;
      if (k == rsa_pulse + 1) rsa_done = 1'b0;
      if (k == rsa_on) rsa_done = 1'b1;
      if (go_busy && (k == 5 || k == 20)) go = 1'b1;
      if (k == 6 || k == 21) go = 1'b0;
    end
    go = 1'b0; ro_done = 1'b0; rsa_done = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst_outs_a", int'(obs[0]), 0);
    check("rst_outs_b", int'(obs[1]), 0);

    // Switcher run with spurious go pulses and inputs changed after go
    run(2'd1, 10, 100, 300, -1, -1, -1, 1'b1, 305);
    check("sw_ro_go_cnt", n_ro[0], 1);
    check("sw_ro_go_cyc", ro_at[0], 2);
    check("sw_first", sw_first[0], 13);
    check("sw_len", n_sw[0], 100);
    check("sw_rsa_go", n_rsa[0], 0);
    check("sw_done_at", done_at[0], 301);
    check("sw_tmo", tmo_done[0], 0);

    // mod_exp with a stale rsa_done in the rsa_go cycle, real done 50 later
    do_reset();
    run(2'd2, 0, 0, 0, -1, 3, 53, 1'b0, 60);
    check("rsa_go_cnt", n_rsa[0], 1);
    check("rsa_go_cyc", rsa_at[0], 3);
    check("rsa_sw", n_sw[0], 0);
    check("rsa_done_at_a", done_at[0], 55);
    check("rsa_done_at_b", done_at[1], 55);
    check("rsa_tmo", tmo_done[0], 0);

    // mod_exp never finishes: abort 64 cycles after WAIT_RSA entry (cycle 3)
    do_reset();
    run(2'd2, 0, 0, -1, -1, -1, -1, 1'b0, 70);
    check("wto_done_at", done_at[1], 67);
    check("wto_tmo", tmo_done[1], 1);
    check("wto_a_busy", done_at[0], -1);

    // Baseline, ro_done pulses only during PRE: sticky gives a one-cycle DRAIN
    do_reset();
    run(2'd0, 5, 0, 3, 4, -1, -1, 1'b0, 12);
    check("early_done_at", done_at[0], 8);
    check("early_tmo", tmo_done[0], 0);

    // DRAIN never completes: abort 64 cycles after DRAIN entry (cycle 2)
    do_reset();
    run(2'd0, 0, 0, -1, -1, -1, -1, 1'b0, 70);
    check("dto_done_at", done_at[1], 66);
    check("dto_tmo", tmo_done[1], 1);

    // Restart from DONE without reset: go clears done and timeout
    run(2'd0, 0, 0, 0, -1, -1, -1, 1'b0, 8);
    check("restart_done_at", done_at[1], 3);
    check("restart_tmo", tmo_done[1], 0);

    // Reserved mode behaves as baseline
    do_reset();
    run(2'd3, 2, 5, 0, -1, -1, -1, 1'b0, 10);
    check("m3_done_at", done_at[0], 5);
    check("m3_sw", n_sw[0], 0);
    check("m3_rsa", n_rsa[0], 0);

    // Switcher with zero victim time never enables
    do_reset();
    run(2'd1, 0, 0, 0, -1, -1, -1, 1'b0, 8);
    check("v0_sw", n_sw[0], 0);
    check("v0_done_at", done_at[0], 3);

    // Full-scale counts on the 8-bit instance
    do_reset();
    run(2'd1, 255, 255, 0, -1, -1, -1, 1'b0, 520);
    check("max_sw_first", sw_first[1], 258);
    check("max_sw_len", n_sw[1], 255);
    check("max_done_at", done_at[1], 513);
    check("max_tmo", tmo_done[1], 0);

    // Asynchronous reset in the middle of VICTIM
    do_reset();
    run(2'd1, 0, 100, -1, -1, -1, -1, 1'b0, 20);
    check("mid_sw_high", int'(obs[0][4]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_outs_a", int'(obs[0]), 0);
    check("mid_rst_outs_b", int'(obs[1]), 0);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_resume", int'(obs[0][2]), 0);
    run(2'd1, 1, 3, 0, -1, -1, -1, 1'b0, 10);
    check("post_rst_ro_go", n_ro[0], 1);
    check("post_rst_sw_first", sw_first[0], 4);
    check("post_rst_sw_len", n_sw[0], 3);
    check("post_rst_done_at", done_at[0], 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/attack_sequencer.md
ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of all cycle-count inputs and internal counters.
REQ-002 Parameter TIMEOUT_CYCLES, default 2**20: maximum cycles spent waiting on rsa_done or ro_done before aborting.
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 go  in  1  start pulse from MMIO; sampled only in IDLE or DONE.
REQ-006 mode  in  2  victim select: 0 = baseline (no victim), 1 = switcher, 2 = mod_exp, 3 = reserved, treated as 0.
REQ-007 pre_cycles  in  CNT_WIDTH  quiet cycles between RO start and victim start.
REQ-008 victim_cycles  in  CNT_WIDTH  switcher_en high-time in mode 1.
REQ-009 ro_done  in  1  level from the RO capture path; all samples have been written.
REQ-010 rsa_done  in  1  level from mod_exp; exponentiation complete.
REQ-011 ro_go  out  1  single-cycle start pulse to the RO capture path.
REQ-012 switcher_en  out  1  level enable for the power switcher.
REQ-013 rsa_go  out  1  single-cycle start pulse to mod_exp.
REQ-014 busy  out  1  high in every state except IDLE and DONE.
REQ-015 done  out  1  high in DONE; cleared by the next accepted go.
REQ-016 timeout  out  1  sticky error flag; set on abort, cleared by the next accepted go.

Function
REQ-017 States SHALL be IDLE, ARM, PRE, VICTIM, WAIT_RSA, DRAIN, DONE.
REQ-018 IDLE/DONE + go SHALL latch mode, pre_cycles and victim_cycles, clear done/timeout, and enter ARM; inputs changing after that point SHALL have no effect on the run.
REQ-019 ARM SHALL assert ro_go for exactly one cycle, then enter PRE.
REQ-020 PRE SHALL last exactly pre_cycles cycles (0 = skip, one cycle minimum in ARM), then go to VICTIM if the latched mode is 1 or 2, otherwise to DRAIN.
REQ-021 VICTIM, mode 1: switcher_en SHALL be high for exactly victim_cycles consecutive cycles (0 = never asserted), then the FSM SHALL enter DRAIN.
REQ-022 VICTIM, mode 2: rsa_go SHALL pulse for one cycle on entry, then the FSM SHALL enter WAIT_RSA.
REQ-023 WAIT_RSA SHALL exit to DRAIN on rsa_done=1; rsa_done asserted in the same cycle as the rsa_go pulse SHALL be ignored.
REQ-024 DRAIN SHALL exit to DONE on ro_done=1.
REQ-025 The timeout counter SHALL reset on entry to WAIT_RSA and to DRAIN; reaching TIMEOUT_CYCLES SHALL set timeout, force switcher_en low, and enter DONE.
REQ-026 A go arriving while busy SHALL be ignored; there is no queueing.
REQ-027 ro_done seen before DRAIN (early capture completion) SHALL be held in a sticky flag and consumed on DRAIN entry, giving a one-cycle DRAIN.
REQ-028 Down-counters SHALL be CNT_WIDTH bits with no wrap; the maximum count (2**CNT_WIDTH-1) SHALL be honoured exactly.
REQ-029 All outputs SHALL be registered; latency from go to ro_go SHALL be 2 cycles.

Reset
REQ-030 rst_n low SHALL force IDLE and drive ro_go, switcher_en, rsa_go, busy, done and timeout to 0, with all counters and the sticky flag cleared.
REQ-031 Reset mid-run SHALL drop switcher_en within the same asynchronous assertion; after reset the block SHALL require a fresh go.

Structure
REQ-032 The state enum and the mode encodings (MODE_BASELINE, MODE_SWITCH, MODE_RSA) SHALL live in a shared package, attack_pkg.
REQ-033 The block SHALL be a single FSM module with one sub-module, cycle_timer (load/decrement/zero flag), instantiated for the phase counter and the timeout counter.

Verification
REQ-034 mode=1, pre=10, victim=100, ro_done at cycle 300 -> ro_go pulse at cycle 2, switcher_en high for cycles 13-112, done at 301, timeout=0.
REQ-035 mode=2, pre=0, rsa_done 50 cycles after rsa_go -> single rsa_go pulse, DRAIN entered on the cycle after rsa_done, switcher_en never high.
REQ-036 mode=2, TIMEOUT_CYCLES=64, rsa_done never asserted -> timeout=1 and done=1 exactly 64 cycles after WAIT_RSA entry.
REQ-037 mode=0, ro_done already high during PRE -> DRAIN lasts one cycle, done asserted.
REQ-038 go pulses at cycles 5 and 20 while busy -> only one ro_go pulse observed.
REQ-039 rst_n low during VICTIM in mode 1 -> switcher_en=0 with no clock edge, state IDLE, and a subsequent go runs normally.
